// File: rtl/rs_load_buffer_if.sv
//------------------------------------------------------------------------------
// rs_load_buffer_if
//   Issue, CDB snoop and memory-FU request/response signals of the load
//   reservation station. The buffer uses slave; the core/FU side uses master.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface rs_load_buffer_if #(
    parameter int TAG_W = 8
);
    logic               flush;
    logic               issue;
    logic [31:0]        base_val_in;
    logic [TAG_W-1:0]   base_tag_in;
    logic [31:0]        offset_in;
    logic [2:0]         mem_u_b_h_w_in;
    logic               full;
    logic               empty;
    logic [TAG_W-1:0]   alloc_tag;
    logic [TAG_W+32:0]  cdb;
    logic               mem_req_valid;
    logic               mem_req_ready;
    logic [31:0]        mem_req_addr;
    logic [2:0]         mem_req_type;
    logic [TAG_W-1:0]   mem_req_tag;
    logic               FU_result_taken;

    modport slave (
        input  flush, issue, base_val_in, base_tag_in, offset_in, mem_u_b_h_w_in,
        input  cdb, mem_req_ready, FU_result_taken,
        output full, empty, alloc_tag, mem_req_valid, mem_req_addr, mem_req_type,
        output mem_req_tag
    );

    modport master (
        output flush, issue, base_val_in, base_tag_in, offset_in, mem_u_b_h_w_in,
        output cdb, mem_req_ready, FU_result_taken,
        input  full, empty, alloc_tag, mem_req_valid, mem_req_addr, mem_req_type,
        input  mem_req_tag
    );
endinterface

`default_nettype wire

// File: rtl/rs_load_buffer.sv
//------------------------------------------------------------------------------
// rs_load_buffer
//   DEPTH-entry circular load reservation station: captures/snoops the base,
//   forms the effective address and dispatches loads to the memory FU in order.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rs_load_buffer #(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 8,
    parameter int ID_BASE = 1
) (
    input  wire logic         clk,
    input  wire logic         rst,
    rs_load_buffer_if.slave   bus
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_full_cnt = c_cnt_w'(DEPTH);
    localparam logic [TAG_W-1:0]   c_id_base  = TAG_W'(ID_BASE);

    logic [c_ptr_w-1:0] r_head;
    logic [c_ptr_w-1:0] r_disp;
    logic [c_ptr_w-1:0] r_tail;
    logic [c_cnt_w-1:0] r_count;
    logic [c_cnt_w-1:0] r_nflight;

    // r_addr holds the raw offset while the entry waits, the effective address after
    logic               r_busy [DEPTH];
    logic               r_wait [DEPTH];
    logic [TAG_W-1:0]   r_qtag [DEPTH];
    logic [31:0]        r_addr [DEPTH];
    logic [2:0]         r_type [DEPTH];

    logic               w_cdb_valid;
    logic [TAG_W-1:0]   w_cdb_tag;
    logic [31:0]        w_cdb_data;
    logic               w_full;
    logic               w_issue;
    logic               w_base_ready;
    logic               w_bypass;
    logic               w_issue_ready;
    logic [31:0]        w_issue_addr;
    logic               w_pending;
    logic               w_req_valid;
    logic               w_fire;
    logic               w_retire;
    logic [DEPTH-1:0]   w_wake;

    assign w_cdb_valid = bus.cdb[TAG_W+32];
    assign w_cdb_tag   = bus.cdb[TAG_W+31:32];
    assign w_cdb_data  = bus.cdb[31:0];

    assign w_full        = (r_count == c_full_cnt);
    assign w_issue       = bus.issue & ~w_full;
    assign w_base_ready  = (bus.base_tag_in == '0);
    assign w_bypass      = w_cdb_valid & (w_cdb_tag == bus.base_tag_in);
    assign w_issue_ready = w_base_ready | w_bypass;
    assign w_issue_addr  = (w_base_ready ? bus.base_val_in : w_cdb_data) + bus.offset_in;

    // In-flight count disambiguates disp==tail (nothing pending vs. all pending)
    assign w_pending   = (r_count != r_nflight);
    assign w_req_valid = w_pending & ~r_wait[r_disp];
    assign w_fire      = w_req_valid & bus.mem_req_ready;
    assign w_retire    = bus.FU_result_taken & (r_nflight != '0);

    always_comb begin
        w_wake = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_wake[i] = r_busy[i] & r_wait[i] & w_cdb_valid & (w_cdb_tag == r_qtag[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head    <= '0;
            r_disp    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_nflight <= '0;
        end else if (bus.flush) begin
            r_head    <= '0;
            r_disp    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_nflight <= '0;
        end else begin
            if (w_issue)  r_tail <= r_tail + 1'b1;
            if (w_fire)   r_disp <= r_disp + 1'b1;
            if (w_retire) r_head <= r_head + 1'b1;
            r_count   <= r_count + c_cnt_w'(w_issue) - c_cnt_w'(w_retire);
            r_nflight <= r_nflight + c_cnt_w'(w_fire) - c_cnt_w'(w_retire);
        end
    end

    // The tail entry is never busy when issue is accepted and the head entry
    // is always in flight when retired, so the branches never collide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_busy[i] <= 1'b0;
                r_wait[i] <= 1'b0;
                r_qtag[i] <= '0;
                r_addr[i] <= '0;
                r_type[i] <= '0;
            end
        end else if (bus.flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_busy[i] <= 1'b0;
                r_wait[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_issue && (r_tail == c_ptr_w'(i))) begin
                    r_busy[i] <= 1'b1;
                    r_wait[i] <= ~w_issue_ready;
                    r_qtag[i] <= bus.base_tag_in;
                    r_addr[i] <= w_issue_ready ? w_issue_addr : bus.offset_in;
                    r_type[i] <= bus.mem_u_b_h_w_in;
                end else if (w_retire && (r_head == c_ptr_w'(i))) begin
                    r_busy[i] <= 1'b0;
                    r_wait[i] <= 1'b0;
                    r_qtag[i] <= '0;
                    r_addr[i] <= '0;
                    r_type[i] <= '0;
                end else if (w_wake[i]) begin
                    r_addr[i] <= w_cdb_data + r_addr[i];
                    r_wait[i] <= 1'b0;
                end
            end
        end
    end

    assign bus.full          = w_full;
    assign bus.empty         = (r_count == '0);
    assign bus.alloc_tag     = c_id_base + TAG_W'(r_tail);
    assign bus.mem_req_valid = w_req_valid;
    assign bus.mem_req_addr  = r_addr[r_disp];
    assign bus.mem_req_type  = r_type[r_disp];
    assign bus.mem_req_tag   = c_id_base + TAG_W'(r_disp);

    a_count_range : assert property (@(posedge clk) disable iff (rst)
        (r_count <= c_full_cnt) && (r_nflight <= r_count));

endmodule

`default_nettype wire

// File: tb/tb_rs_load_buffer.sv
//------------------------------------------------------------------------------
// tb_rs_load_buffer
//   Directed self-checking bench for rs_load_buffer (DEPTH=4, TAG_W=8, ID_BASE=1).
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_rs_load_buffer;

    logic clk;
    logic rst;
    int   n_total;
    int   n_bad;

    rs_load_buffer_if #(.TAG_W(8)) bus ();

    rs_load_buffer #(.DEPTH(4), .TAG_W(8), .ID_BASE(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_issue(input logic [7:0] tg, input logic [31:0] val,
                             input logic [31:0] off, input logic [2:0] ty);
        bus.issue          = 1'b1;
        bus.base_tag_in    = tg;
        bus.base_val_in    = val;
        bus.offset_in      = off;
        bus.mem_u_b_h_w_in = ty;
    endtask

    task automatic chk_req(input string tag, input logic v, input logic [31:0] a,
                           input logic [7:0] t);
        check({tag, "_valid"}, 64'(bus.mem_req_valid), 64'(v));
        check({tag, "_addr"},  64'(bus.mem_req_addr),  64'(a));
        check({tag, "_tag"},   64'(bus.mem_req_tag),   64'(t));
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst = 1'b1;
        bus.flush = 1'b0; bus.issue = 1'b0; bus.base_val_in = '0; bus.base_tag_in = '0;
        bus.offset_in = '0; bus.mem_u_b_h_w_in = '0; bus.cdb = '0;
        bus.mem_req_ready = 1'b0; bus.FU_result_taken = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset values
        check("rst_full",  64'(bus.full), 64'd0);
        check("rst_empty", 64'(bus.empty), 64'd1);
        check("rst_alloc", 64'(bus.alloc_tag), 64'd1);
        check("rst_type",  64'(bus.mem_req_type), 64'd0);
        chk_req("rst", 1'b0, 32'h0, 8'd1);

        // Ready base: dispatch next cycle, then retire
        bus.mem_req_ready = 1'b1;
        set_issue(8'd0, 32'h1000, 32'h10, 3'b010);
        tick(); bus.issue = 1'b0;
        chk_req("t1", 1'b1, 32'h1010, 8'd1);
        check("t1_type", 64'(bus.mem_req_type), 64'd2);
        tick();
        check("t1_valid_after", 64'(bus.mem_req_valid), 64'd0);
        bus.FU_result_taken = 1'b1;
        tick(); bus.FU_result_taken = 1'b0;
        check("t1_empty", 64'(bus.empty), 64'd1);
        check("t1_alloc", 64'(bus.alloc_tag), 64'd2);

        // Pending base woken by CDB; younger ready load must wait behind it
        set_issue(8'd5, 32'hDEADBEEF, 32'hFFFF_FFFC, 3'b001);
        tick();
        check("t2_wait_valid", 64'(bus.mem_req_valid), 64'd0);
        set_issue(8'd0, 32'h50, 32'h0, 3'b100);
        tick(); bus.issue = 1'b0;
        check("t2_order_valid", 64'(bus.mem_req_valid), 64'd0);
        bus.cdb = {1'b1, 8'd5, 32'h2000};
        tick(); bus.cdb = '0;
        chk_req("t2_wake", 1'b1, 32'h1FFC, 8'd2);
        tick();
        chk_req("t2_second", 1'b1, 32'h50, 8'd3);
        tick();
        check("t2_idle", 64'(bus.mem_req_valid), 64'd0);
        bus.FU_result_taken = 1'b1;
        tick(); tick(); bus.FU_result_taken = 1'b0;
        check("t2_empty", 64'(bus.empty), 64'd1);

        // Same-cycle CDB bypass at issue
        set_issue(8'd7, 32'h12345678, 32'h20, 3'b101);
        bus.cdb = {1'b1, 8'd7, 32'h300};
        tick(); bus.issue = 1'b0; bus.cdb = '0;
        chk_req("t3_bypass", 1'b1, 32'h320, 8'd4);
        tick();
        bus.FU_result_taken = 1'b1;
        tick(); bus.FU_result_taken = 1'b0;
        check("t3_empty", 64'(bus.empty), 64'd1);
        check("t3_alloc_wrap", 64'(bus.alloc_tag), 64'd1);

        // Fill, refuse when full, issue+retire together, wrap
        bus.mem_req_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            set_issue(8'd0, 32'(k * 32'h100), 32'h0, 3'(k));
            tick();
        end
        check("t4_full", 64'(bus.full), 64'd1);
        check("t4_alloc", 64'(bus.alloc_tag), 64'd1);
        set_issue(8'd0, 32'hDEAD, 32'h0, 3'd7);
        tick(); bus.issue = 1'b0;
        check("t4_full_refuse", 64'(bus.full), 64'd1);
        chk_req("t4_head", 1'b1, 32'h100, 8'd1);
        bus.mem_req_ready = 1'b1;
        tick(); bus.mem_req_ready = 1'b0;
        chk_req("t4_disp1", 1'b1, 32'h200, 8'd2);
        bus.FU_result_taken = 1'b1;
        tick(); bus.FU_result_taken = 1'b0;
        check("t4_unfull", 64'(bus.full), 64'd0);
        bus.mem_req_ready = 1'b1;
        tick(); bus.mem_req_ready = 1'b0;
        chk_req("t4_disp2", 1'b1, 32'h300, 8'd3);
        set_issue(8'd0, 32'h500, 32'h0, 3'd1);
        bus.FU_result_taken = 1'b1;
        tick(); bus.FU_result_taken = 1'b0;
        check("t4_iss_ret_full", 64'(bus.full), 64'd0);
        check("t4_iss_ret_empty", 64'(bus.empty), 64'd0);
        set_issue(8'd0, 32'h600, 32'h0, 3'd2);
        tick(); bus.issue = 1'b0;
        check("t4_refill_full", 64'(bus.full), 64'd1);
        bus.mem_req_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk_req($sformatf("t4_drain%0d", k), 1'b1, 32'(32'h300 + k * 32'h100),
                    8'((k + 2) % 4 + 1));
            tick();
        end
        bus.mem_req_ready = 1'b0;
        check("t4_all_flight", 64'(bus.mem_req_valid), 64'd0);
        bus.FU_result_taken = 1'b1;
        repeat (4) tick();
        bus.FU_result_taken = 1'b0;
        check("t4_drained", 64'(bus.empty), 64'd1);
        check("t4_alloc_end", 64'(bus.alloc_tag), 64'd3);

        // Stall stability, then flush with waiting entries
        set_issue(8'd0, 32'hA0, 32'h4, 3'd6);
        tick(); bus.issue = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_req($sformatf("t5_hold%0d", k), 1'b1, 32'hA4, 8'd3);
            check($sformatf("t5_hold_type%0d", k), 64'(bus.mem_req_type), 64'd6);
        end
        bus.mem_req_ready = 1'b1;
        tick(); bus.mem_req_ready = 1'b0;
        set_issue(8'd9, 32'h0, 32'h8, 3'd0);
        tick();
        set_issue(8'd10, 32'h0, 32'h8, 3'd0);
        tick(); bus.issue = 1'b0;
        check("t5_waiting", 64'(bus.mem_req_valid), 64'd0);
        bus.flush = 1'b1;
        tick(); bus.flush = 1'b0;
        check("t5_flush_valid", 64'(bus.mem_req_valid), 64'd0);
        check("t5_flush_empty", 64'(bus.empty), 64'd1);
        check("t5_flush_alloc", 64'(bus.alloc_tag), 64'd1);
        bus.FU_result_taken = 1'b1;
        tick(); bus.FU_result_taken = 1'b0;
        check("t5_stale_empty", 64'(bus.empty), 64'd1);
        check("t5_stale_full", 64'(bus.full), 64'd0);
        bus.cdb = {1'b1, 8'd9, 32'h4000};
        tick(); bus.cdb = '0;
        check("t5_stale_cdb", 64'(bus.mem_req_valid), 64'd0);

        // Asynchronous reset between edges
        for (int k = 1; k <= 3; k++) begin
            set_issue(8'd0, 32'(k * 32'h10), 32'h0, 3'd3);
            tick();
        end
        bus.issue = 1'b0;
        check("t6_busy", 64'(bus.empty), 64'd0);
        #3 rst = 1'b1;
        #1;
        check("t6_arst_empty", 64'(bus.empty), 64'd1);
        check("t6_arst_full", 64'(bus.full), 64'd0);
        check("t6_arst_alloc", 64'(bus.alloc_tag), 64'd1);
        check("t6_arst_type", 64'(bus.mem_req_type), 64'd0);
        chk_req("t6_arst", 1'b0, 32'h0, 8'd1);
        #1 rst = 1'b0;
        set_issue(8'd0, 32'h77, 32'h0, 3'd1);
        tick(); bus.issue = 1'b0;
        chk_req("t6_post", 1'b1, 32'h77, 8'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
